// File: rtl/adsr_note_sequencer.sv
// adsr_note_sequencer: programmable step sequencer driving one square-wave/ADSR voice
// Ports: clk/reset (sync, active-high); wr_en/wr_addr/wr_data write the pattern
// (word = {last, duration[7:0], rest, note[5:0]}); gate_ticks sets note_off time
// inside each step; loop_en restarts at step 0 at pattern end; start/stop control
// playback; freq_select/note_on/note_off feed the voice; busy, step_idx and done
// report progress.
module adsr_note_sequencer #(
  parameter int STEPS = 16,
  parameter int TICK_DIV = 25000,
  localparam int AW = $clog2(STEPS),
  localparam int PW = $clog2(TICK_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [7:0]    gate_ticks,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
  output logic [5:0]    freq_select,
  output logic          note_on,
  output logic          note_off,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;
  state_t state, state_n;
  logic [15:0] mem [STEPS];
  logic [15:0] word, word_n;
  logic [PW-1:0] presc, presc_n;
  logic [7:0] elapsed, el_n, el_inc, d, g;
  logic sounding, snd_n, on_n, off_n, done_n, tick;
  logic [5:0] freq_n;
  logic [AW-1:0] step_n;
  assign busy = state != IDLE;
  assign d = word[14:7] == 8'd0 ? 8'd1 : word[14:7];
  assign g = gate_ticks == 8'd0 ? 8'd1 : gate_ticks;
  assign tick = presc == PW'(TICK_DIV - 1);
  assign el_inc = elapsed + 8'd1;
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < STEPS; i++) mem[i] <= '0;
    else if (wr_en)
      mem[wr_addr] <= wr_data;
  always_comb begin
    state_n = state;
    step_n = step_idx;
    freq_n = freq_select;
    on_n = 1'b0;
    off_n = 1'b0;
    done_n = 1'b0;
    word_n = word;
    presc_n = presc;
    el_n = elapsed;
    snd_n = sounding;
    if (stop) begin
      if (state != IDLE) begin
        state_n = IDLE;
        off_n = sounding;
        snd_n = 1'b0;
      end
    end else if (start) begin
      state_n = FETCH;
      step_n = '0;
      off_n = sounding;
      snd_n = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          word_n = mem[step_idx];
          freq_n = mem[step_idx][5:0];
          on_n = ~mem[step_idx][6];
          snd_n = ~mem[step_idx][6];
          presc_n = '0;
          el_n = '0;
          state_n = PLAY;
        end
        PLAY: begin
          presc_n = tick ? '0 : presc + PW'(1);
          if (tick) begin
            el_n = el_inc;
            // gate end, or step end when the gate is at least the duration
            if (sounding && (el_inc == g || el_inc == d)) begin
              off_n = 1'b1;
              snd_n = 1'b0;
            end
            if (el_inc == d) begin
              if (word[15] || step_idx == AW'(STEPS - 1)) begin
                if (loop_en) begin
                  step_n = '0;
                  state_n = FETCH;
                end else begin
                  done_n = 1'b1;
                  state_n = IDLE;
                end
              end else begin
                step_n = step_idx + AW'(1);
                state_n = FETCH;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      step_idx <= '0;
      freq_select <= '0;
      note_on <= 1'b0;
      note_off <= 1'b0;
      done <= 1'b0;
      word <= '0;
      presc <= '0;
      elapsed <= '0;
      sounding <= 1'b0;
    end else begin
      state <= state_n;
      step_idx <= step_n;
      freq_select <= freq_n;
      note_on <= on_n;
      note_off <= off_n;
      done <= done_n;
      word <= word_n;
      presc <= presc_n;
      elapsed <= el_n;
      sounding <= snd_n;
    end
endmodule

// File: tb/tb_adsr_note_sequencer.sv
// tb_adsr_note_sequencer: scoreboard bench for adsr_note_sequencer with TICK_DIV=4
module tb_adsr_note_sequencer;
  localparam logic [2:0] ON = 3'b100, OFF = 3'b010, DN = 3'b001;
  logic clk = 0, reset = 1, wr_en = 0, loop_en = 0, start = 0, stop = 0;
  logic [3:0] wr_addr = 0;
  logic [15:0] wr_data = 0;
  logic [7:0] gate_ticks = 0;
  logic [5:0] freq_select;
  logic note_on, note_off, busy, done;
  logic [3:0] step_idx;
  int cyc = 0, n_checks = 0, n_fail = 0, t;
  typedef struct {int c; logic [2:0] k; int f; int s;} ev_t;
  ev_t q[$];

  adsr_note_sequencer #(.STEPS(16), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .gate_ticks(gate_ticks), .loop_en(loop_en), .start(start), .stop(stop),
    .freq_select(freq_select), .note_on(note_on), .note_off(note_off), .busy(busy),
    .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk)
    if (note_on || note_off || done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event at cycle %0d: got on/off/done=%b%b%b, expected none", cyc, note_on, note_off, done);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("event_cycle", cyc, e.c);
        chk("event_kind", int'({note_on, note_off, done}), int'(e.k));
        chk("event_freq", int'(freq_select), e.f);
        chk("event_step", int'(step_idx), e.s);
      end
    end

  function automatic logic [15:0] w(int n, bit r, int d, bit l);
    return {l, 8'(d), r, 6'(n)};
  endfunction

  task automatic ex(int c, logic [2:0] k, int f, int s);
    ev_t e;
    e = '{c, k, f, s};
    q.push_back(e);
  endtask

  task automatic wait_to(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(int a, logic [15:0] d);
    wr_en = 1;
    wr_addr = 4'(a);
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 0;
  endtask

  task automatic pulse_start(output int t0);
    start = 1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_freq"}, int'(freq_select), 0);
    chk({tag, "_on"}, int'(note_on), 0);
    chk({tag, "_off"}, int'(note_off), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_step"}, int'(step_idx), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 0;
    // single note with early gate, then done
    gate_ticks = 2;
    wr(0, w(33, 0, 3, 1));
    pulse_start(t);
    ex(t + 2, ON, 33, 0); ex(t + 10, OFF, 33, 0); ex(t + 14, DN, 33, 0);
    wait_to(t + 5);
    chk("t1_busy_mid", int'(busy), 1);
    wait_to(t + 15);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_queue", q.size(), 0);
    // gate longer than duration: note_off lands on the FETCH cycle
    gate_ticks = 5;
    wr(0, w(10, 0, 2, 0)); wr(1, w(20, 0, 2, 0)); wr(2, w(30, 0, 2, 1));
    pulse_start(t);
    ex(t + 2, ON, 10, 0); ex(t + 10, OFF, 10, 1); ex(t + 11, ON, 20, 1);
    ex(t + 19, OFF, 20, 2); ex(t + 20, ON, 30, 2); ex(t + 28, OFF | DN, 30, 2);
    wait_to(t + 29);
    chk("t2_busy_after", int'(busy), 0);
    chk("t2_queue", q.size(), 0);
    // rest step is silent but still occupies its duration
    gate_ticks = 1;
    wr(0, w(11, 0, 1, 0)); wr(1, w(12, 1, 1, 0)); wr(2, w(13, 0, 1, 1));
    pulse_start(t);
    ex(t + 2, ON, 11, 0); ex(t + 6, OFF, 11, 1); ex(t + 12, ON, 13, 2); ex(t + 16, OFF | DN, 13, 2);
    for (int i = 6; i <= 10; i++) begin
      wait_to(t + i);
      chk("t3_rest_step", int'(step_idx), 1);
    end
    wait_to(t + 11);
    chk("t3_step2", int'(step_idx), 2);
    wait_to(t + 18);
    chk("t3_queue", q.size(), 0);
    // looping two-step pattern, then stop mid-note
    loop_en = 1;
    wr(0, w(40, 0, 1, 0)); wr(1, w(41, 0, 1, 1));
    pulse_start(t);
    ex(t + 2, ON, 40, 0); ex(t + 6, OFF, 40, 1); ex(t + 7, ON, 41, 1); ex(t + 11, OFF, 41, 0);
    ex(t + 12, ON, 40, 0); ex(t + 16, OFF, 40, 1); ex(t + 17, ON, 41, 1); ex(t + 19, OFF, 41, 1);
    wait_to(t + 18);
    stop = 1;
    wait_to(t + 19);
    stop = 0;
    chk("t4_busy_stop", int'(busy), 0);
    wait_to(t + 30);
    chk("t4_step_hold", int'(step_idx), 1);
    chk("t4_queue", q.size(), 0);
    loop_en = 0;
    // restart while playing step 2, then stop+start together
    gate_ticks = 5;
    wr(0, w(50, 0, 2, 0)); wr(1, w(51, 0, 2, 0)); wr(2, w(52, 0, 2, 1));
    pulse_start(t);
    ex(t + 2, ON, 50, 0); ex(t + 10, OFF, 50, 1); ex(t + 11, ON, 51, 1);
    ex(t + 19, OFF, 51, 2); ex(t + 20, ON, 52, 2); ex(t + 23, OFF, 52, 0);
    ex(t + 24, ON, 50, 0); ex(t + 28, OFF, 50, 0);
    wait_to(t + 22);
    start = 1;
    wait_to(t + 23);
    start = 0;
    chk("t5_restart_step", int'(step_idx), 0);
    wait_to(t + 27);
    start = 1;
    stop = 1;
    wait_to(t + 28);
    start = 0;
    stop = 0;
    chk("t5_stopwins_busy", int'(busy), 0);
    wait_to(t + 40);
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_queue", q.size(), 0);
    // zero duration and zero gate behave as one tick
    gate_ticks = 0;
    wr(0, w(60, 0, 0, 0)); wr(1, w(61, 0, 0, 1));
    pulse_start(t);
    ex(t + 2, ON, 60, 0); ex(t + 6, OFF, 60, 1); ex(t + 7, ON, 61, 1); ex(t + 11, OFF | DN, 61, 1);
    wait_to(t + 6);
    chk("t6_advance", int'(step_idx), 1);
    wait_to(t + 13);
    chk("t6_queue", q.size(), 0);
    // reset mid-note clears outputs and the pattern
    gate_ticks = 2;
    wr(0, w(33, 0, 3, 1));
    pulse_start(t);
    ex(t + 2, ON, 33, 0);
    wait_to(t + 5);
    reset = 1;
    wait_to(t + 6);
    chk_zero("midreset");
    chk("t7_queue", q.size(), 0);
    reset = 0;
    pulse_start(t);
    ex(t + 2, ON, 0, 0); ex(t + 6, OFF, 0, 1); ex(t + 7, ON, 0, 1); ex(t + 9, OFF, 0, 1);
    wait_to(t + 8);
    stop = 1;
    wait_to(t + 9);
    stop = 0;
    wait_to(t + 15);
    chk("t7_busy_end", int'(busy), 0);
    chk("t7_queue_end", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adsr_note_sequencer.md
Name: adsr_note_sequencer

Overview:
- Step sequencer that drives the square-wave/ADSR voice. It produces that voice's freq_select, note_on and note_off.
- Plays a programmable pattern of up to STEPS notes; each step has a pitch, a rest flag, a duration and an end marker.
- A shared gate length sets when note_off is issued inside each step.
- A tick prescaler derives musical time from the 25 MHz system clock.

Parameters:
- STEPS, 16, pattern depth; must be a power of two; AW = log2(STEPS).
- TICK_DIV, 25000, clk cycles per tick (1 ms at 25 MHz); must be ≥ 2.

Ports:
- clk  in  1  system clock (25 MHz).
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  pattern write strobe.
- wr_addr  in  AW  step index to write.
- wr_data  in  16  step word: [5:0] note, [6] rest, [14:7] duration in ticks, [15] last.
- gate_ticks  in  8  ticks from note_on to note_off within a step.
- loop_en  in  1  at the end of the pattern, restart at step 0 instead of stopping.
- start  in  1  single-cycle pulse; begin playback at step 0.
- stop  in  1  single-cycle pulse; abort playback.
- freq_select  out  6  pitch to the voice.
- note_on  out  1  single-cycle pulse.
- note_off  out  1  single-cycle pulse.
- busy  out  1  high while not IDLE.
- step_idx  out  AW  current step index.
- done  out  1  single-cycle pulse when the pattern ends without looping.

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - All outputs go to 0: freq_select, note_on, note_off, busy, step_idx, done.
  - Prescaler, elapsed counter and sounding flag clear.
  - All pattern words clear to 0.
- Pattern memory:
  - Written on any clk edge with wr_en, including while playing.
  - A write to the playing step takes effect on that step's next fetch.
- States:
  - IDLE: start → FETCH with step_idx=0.
  - FETCH, one cycle:
    - Latch the word at step_idx; freq_select <= note.
    - note_on <= ~rest; sounding <= ~rest.
    - Clear prescaler and elapsed; go to PLAY.
    - Effective duration D = max(duration,1); effective gate G = max(gate_ticks,1).
  - PLAY:
    - Prescaler counts 0..TICK_DIV-1; a tick occurs when it equals TICK_DIV-1; elapsed increments on each tick.
    - Tick making elapsed==G with sounding and G<D: note_off <= 1, sounding <= 0.
    - Tick making elapsed==D:
      - If sounding, note_off <= 1 and sounding <= 0 (gate ≥ duration case).
      - If last==1 or step_idx==STEPS-1: with loop_en, step_idx <= 0 and go to FETCH; otherwise done <= 1 and go to IDLE.
      - Otherwise step_idx <= step_idx+1 and go to FETCH.
- Resulting timing:
  - start sampled at edge k gives note_on high in cycle k+2.
  - note_off occurs TICK_DIV*min(G,D) cycles after note_on.
  - The next note_on occurs TICK_DIV*D+1 cycles after the previous note_on.
- freq_select holds its value after note_off and while IDLE, so the voice's release uses the same pitch.
- stop while busy:
  - Next edge goes to IDLE with busy=0 and no done pulse.
  - note_off <= 1 if sounding.
  - step_idx holds.
- start while busy:
  - note_off <= 1 if sounding; step_idx <= 0; go to FETCH.
  - The new note_on follows one cycle later.
- Simultaneous stop and start: stop wins.
- Simultaneous note_off and next note_on are impossible; they are always at least one cycle apart.
- stop while IDLE: ignored.
- gate_ticks and loop_en are sampled live, not latched per step.
- Width rules:
  - elapsed is 8 bits and never exceeds D ≤ 255.
  - The prescaler is sized for TICK_DIV-1.
  - step_idx wraps only via the rules above.

Test Plan:
- TICK_DIV=4. Step0 = {note 33, dur 3}, gate_ticks=2, step0 last=1, loop_en=0. start at cycle 0 → note_on and freq_select=33 at cycle 2; note_off at cycle 10; done at cycle 14; busy=0 from cycle 15.
- Three steps with notes 10, 20, 30, each dur 2, last set on step 2; gate_ticks=5 (≥dur) → each note_off coincides with the FETCH cycle; note_on at cycles 2, 11, 20; freq_select sequence 10, 20, 30.
- Step1 rest=1 with dur 1 → no note_on or note_off during step1; step_idx=1 for 5 cycles; step2 plays normally.
- loop_en=1 on a 2-step pattern → step_idx sequence 0,1,0,1 and no done pulse. stop mid-note → a single note_off the next cycle, busy=0, no done.
- start pulsed during step 2 of a playing pattern → note_off next cycle, then note_on with step0's note one cycle later, step_idx=0. stop+start in the same cycle → IDLE.
- dur=0 and gate_ticks=0 → both treated as 1 tick: note_off and the step advance both occur 4 cycles after note_on. reset asserted mid-PLAY → all outputs 0 the next cycle and pattern memory reads back as zero.
